// File: rtl/riscv_defs.sv
// Shared RV32 definitions: opcodes, fetch FSM states and immediate decoders.
// Used by the fetch front end and the decoder.
package riscv_defs;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        READY
    } fetch_state_t;

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Static next-PC predictor: JAL and backward branches taken,
// everything else (JALR included) falls through to pc+4.
module fetch_next_pc
    import riscv_defs::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        pred_taken
);

    logic [6:0] opcode;
    assign opcode = inst[6:0];

    always_comb begin
        next_pc    = pc + 32'd4;
        pred_taken = 1'b0;
        unique case (1'b1)
            (opcode == OP_JAL): begin
                next_pc    = pc + imm_j(inst);
                pred_taken = 1'b1;
            end
            (opcode == OP_BRANCH && inst[31]): begin
                next_pc    = pc + imm_b(inst);
                pred_taken = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch front end: one outstanding word read, static prediction,
// RoB redirect with discard of an in-flight word.
module instruction_fetcher
    import riscv_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        issue_ready,
    output logic        fetch_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        pred_taken,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    input  logic        jump_valid,
    input  logic [31:0] jump_pc
);

    fetch_state_t state;
    logic         discard;
    logic [31:0]  fetch_pc;
    logic [31:0]  next_pc_q;
    logic [31:0]  np_next;
    logic         np_pred;

    // Predict on the incoming word so the prediction is registered with it.
    fetch_next_pc u_next_pc (
        .inst       (mem_data),
        .pc         (fetch_pc),
        .next_pc    (np_next),
        .pred_taken (np_pred)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            discard     <= 1'b0;
            fetch_pc    <= RESET_PC;
            next_pc_q   <= RESET_PC;
            fetch_ready <= 1'b0;
            inst        <= 32'h0;
            pc          <= RESET_PC;
            pred_taken  <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= RESET_PC;
        end else if (rdy_in) begin
            unique case (state)
                IDLE: begin
                    if (jump_valid) begin
                        fetch_pc <= jump_pc;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                        state    <= WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (mem_done) begin
                        mem_req <= 1'b0;
                        if (jump_valid || discard) begin
                            discard <= 1'b0;
                            state   <= IDLE;
                            if (jump_valid) fetch_pc <= jump_pc;
                        end else begin
                            inst        <= mem_data;
                            pc          <= fetch_pc;
                            pred_taken  <= np_pred;
                            next_pc_q   <= np_next;
                            fetch_ready <= 1'b1;
                            state       <= READY;
                        end
                    end else if (jump_valid) begin
                        // Request cannot be aborted; drop its word on return.
                        fetch_pc <= jump_pc;
                        discard  <= 1'b1;
                    end
                end
                READY: begin
                    if (jump_valid) begin
                        fetch_pc    <= jump_pc;
                        fetch_ready <= 1'b0;
                        state       <= IDLE;
                    end else if (issue_ready) begin
                        fetch_pc    <= next_pc_q;
                        fetch_ready <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
